// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a single registered output stage.
// Channel choice is round-robin (MODE=0) or driven by an external select (MODE=1).
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N),
    parameter int MODE  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SELW-1:0]  ptr_reg;
    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic             grant_any;
    logic             load_en;
    logic [WIDTH-1:0] chan_data [N];
    int               scan_idx;

    assign load_en = !out_valid || out_ready;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        // Held low during reset even though the empty stage would otherwise accept.
        assign in_ready[gi]  = grant[gi] && load_en && !rst;
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = 0;
        if (MODE == 0) begin
            // Cyclic scan starting at the pointer; the first valid channel wins.
            for (int k = 0; k < N; k++) begin
                scan_idx = int'(ptr_reg) + k;
                if (scan_idx >= N) begin
                    scan_idx = scan_idx - N;
                end
                if (!grant_any && in_valid[scan_idx]) begin
                    grant[scan_idx] = 1'b1;
                    grant_idx       = SELW'(scan_idx);
                    grant_any       = 1'b1;
                end
            end
        end else begin
            if (int'(sel) < N) begin
                if (in_valid[sel]) begin
                    grant[sel] = 1'b1;
                    grant_idx  = sel;
                    grant_any  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr_reg   <= '0;
        end else begin
            if (grant_any && load_en) begin
                out_data  <= chan_data[grant_idx];
                out_chan  <= grant_idx;
                out_valid <= 1'b1;
                if (MODE == 0) begin
                    ptr_reg <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised, registered N-channel stream multiplexer: the sequential successor to the gate-level 2:1 mux. Selects one of N valid/ready input channels per cycle, either round-robin or by an external select, and registers the winner into a single-entry output stage with its channel index. It is the front-end merge point wherever several producers share one downstream consumer.

## Interface
- `WIDTH`, 8: data bits per channel, ≥1.
- `N`, 4: number of input channels, ≥2.
- `SELW`, `$clog2(N)`: width of `sel` and `out_chan`. Derived; do not override.
- `MODE`, 0: 0 = round-robin arbitration, 1 = fixed select via `sel`.

Ports:
- `clk`  in  1: single clock; all state is updated on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `in_data`  in  N*WIDTH: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_valid`  in  N: per-channel valid.
- `in_ready`  out  N: per-channel ready, combinational.
- `sel`  in  SELW: channel select, used only when MODE=1.
- `out_data`  out  WIDTH: registered data.
- `out_chan`  out  SELW: registered index of the source channel.
- `out_valid`  out  1: output register holds a word.
- `out_ready`  in  1: downstream accepts the word.

## Operation
- Transfer on any handshake port happens when valid && ready are both high at a rising edge.
- `load_en = !out_valid || out_ready`. The output stage can accept a word when it is empty or is being drained in the same cycle.
- Grant is combinational and one-hot or zero:
  - MODE=0: scan channels cyclically starting at pointer `ptr`. The first i with `in_valid[i]` wins.
  - MODE=1: channel `sel` wins if `in_valid[sel]` is high. If `sel ≥ N`, nothing is granted.
- `in_ready[i] = grant[i] && load_en`. At most one bit of `in_ready` is high. A non-granted channel never sees ready.
- On an input transfer:
  - `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
  - MODE=0 only: `ptr <= (g+1) mod N`, with a wrap from N-1 to 0.
- If `out_ready && out_valid` and no grant: `out_valid <= 0`. `out_data` and `out_chan` hold their last values.
- `ptr` is unchanged when no transfer occurs, and unchanged in MODE=1.
- When the output is full and `out_ready` is low:
  - all `in_ready` are 0;
  - `out_data` and `out_chan` hold stable.
- No word is dropped or duplicated. Sources must hold `in_data` stable while valid and not ready. `in_valid` depends only on the source.
- `in_ready` depends on `in_valid`. There is no combinational path from `out_ready` to `out_valid`.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_chan=0`, `ptr=0`. `in_ready` is 0 for all channels while `rst` is high.
- Asynchronous assertion clears all state immediately, including mid-burst. A word held in the output stage is discarded. Deassertion takes effect at the next rising edge.
- Latency: input transfer at edge k gives `out_valid` high after edge k.
- Throughput: one word per cycle sustained while `out_ready` stays high.
- Simultaneous drain and load in one cycle: the new word replaces the old one with no bubble.
- Round-robin fairness: with all N channels continuously valid and `out_ready=1`, grants cycle 0,1,…,N-1,0,… . Each channel waits at most N-1 transfers.
- Changing `sel` (MODE=1) while the output is stalled does not affect the registered word. Only the next grant follows the new `sel`.

## Test plan
- Reset mid-stream: N=4, MODE=0, words in flight, assert `rst` between edges. Expected: `out_valid`, `out_data`, `out_chan` and `in_ready` go to 0 immediately. After release, the first grant is channel 0.
- RR fairness: N=4, all `in_valid=1111`, `in_data = {0x44,0x33,0x22,0x11}`, `out_ready=1`, 8 cycles. Expected: `out_chan = 0,1,2,3,0,1,2,3` and `out_data = 0x11,0x22,0x33,0x44,…`.
- RR skip and wrap: `ptr=3`, `in_valid=0101`. Expected: channel 0 is granted and `ptr` becomes 1. The next grant is channel 2.
- Backpressure: output full with 0x22, `out_ready=0` for 3 cycles, `in_valid=1111`. Expected: `in_ready=0000` and `out_data` stays 0x22. Then `out_ready=1`: the word drains and a new one loads in the same cycle.
- Fixed select: MODE=1, `sel=2`, `in_valid=1111`, `in_data[2]=0xA5`. Expected: only `in_ready[2]` rises, then `out_data=0xA5`, `out_chan=2`. With `sel=1` and `in_valid[1]=0`: no grant, and `out_valid` clears after a drain.
- Randomised scoreboard: WIDTH=16, N=5, random `in_valid` and `out_ready`, 10k cycles. Expected: every accepted input word appears exactly once, in order per channel, with the correct `out_chan`.
